// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath.
// It drives the datapath selects and enables for each state, waits on mem_ready and counts retired instructions.
module multicycle_control_fsm #(
  parameter int         COUNT_W  = 32,
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    I_EXEC   = 4'd11,
    I_WB     = 4'd12
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [COUNT_W-1:0] count_q;
  logic               retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      // PC+4 is computed by the ALU while the instruction is fetched; both loads wait for memory.
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = R_EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = I_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = run ? FETCH : IDLE;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // run is only honoured at an instruction boundary, so a running instruction always completes.
    if (retire) state_d = run ? FETCH : IDLE;
    instr_done = retire;
  end

  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm.
// Random instruction streams are expanded into expected per-cycle control words and boundary records.
module tb_multicycle_control_fsm;

  localparam int CW = 4;
  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

  logic          clk, rst, run, mem_ready;
  logic [5:0]    opcode;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0]    pc_source, alu_src_b, alu_op;
  logic [CW-1:0] instr_count;
  logic [3:0]    state;

  multicycle_control_fsm #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .instr_done(instr_done), .instr_count(instr_count),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       illegal_op, instr_done;
  } ctl_t;

  typedef struct {
    bit illegal;
    int gap;
    int count;
  } ret_t;

  ctl_t exp_q[$];
  ret_t ret_q[$];
  int   checks  = 0;
  int   fails   = 0;
  int   since   = 0;
  int   retired = 0;
  int   gap     = 0;

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
  endfunction

  function automatic logic [5:0] op_of(int kind);
    logic [5:0] op;
    case (kind)
      K_R:     op = 6'h00;
      K_LW:    op = 6'h23;
      K_SW:    op = 6'h2B;
      K_BEQ:   op = 6'h04;
      K_J:     op = 6'h02;
      K_ADDI:  op = 6'h08;
      default: begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end
    endcase
    return op;
  endfunction

  function automatic ctl_t w_state(int st);
    ctl_t w = '0;
    w.st = 4'(st);
    return w;
  endfunction

  function automatic ctl_t w_fetch(bit last);
    ctl_t w = w_state(1);
    w.mem_read  = 1'b1;
    w.alu_src_b = 2'b01;
    w.pc_write  = last;
    w.ir_write  = last;
    return w;
  endfunction

  function automatic ctl_t w_decode(bit ill);
    ctl_t w = w_state(2);
    w.alu_src_b  = 2'b11;
    w.illegal_op = ill;
    return w;
  endfunction

  function automatic ctl_t w_memaddr();
    ctl_t w = w_state(3);
    w.alu_src_a = 1'b1;
    w.alu_src_b = 2'b10;
    return w;
  endfunction

  function automatic ctl_t w_memwr(bit last);
    ctl_t w = w_state(6);
    w.mem_write  = 1'b1;
    w.i_or_d     = 1'b1;
    w.instr_done = last;
    return w;
  endfunction

  function automatic ctl_t actual();
    ctl_t a;
    a.st = state;
    a.pc_write = pc_write;  a.pc_write_cond = pc_write_cond;  a.pc_source = pc_source;
    a.i_or_d = i_or_d;  a.mem_read = mem_read;  a.mem_write = mem_write;  a.ir_write = ir_write;
    a.reg_dst = reg_dst;  a.mem_to_reg = mem_to_reg;  a.reg_write = reg_write;
    a.alu_src_a = alu_src_a;  a.alu_src_b = alu_src_b;  a.alu_op = alu_op;
    a.illegal_op = illegal_op;  a.instr_done = instr_done;
    return a;
  endfunction

  function automatic logic mid_run(bit drop);
    return drop ? 1'b0 : 1'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(string name, ctl_t a, ctl_t e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got state=%0d word=%h, expected state=%0d word=%h",
               name, $time, a.st, a, e.st, e);
    end
  endtask

  task automatic checkValue(string name, int got, int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  // One clock cycle of stimulus together with the control word the DUT must show during it.
  task automatic issue(logic mr, logic rn, logic [5:0] op, ctl_t w);
    @(posedge clk);
    #1;
    mem_ready = mr;
    run       = rn;
    opcode    = op;
    exp_q.push_back(w);
    since++;
  endtask

  task automatic boundary(logic mr, logic run_end, logic [5:0] op, ctl_t w, bit ill);
    ret_t r;
    issue(mr, run_end, op, w);
    r.illegal = ill;
    r.gap     = since;
    r.count   = retired % (1 << CW);
    ret_q.push_back(r);
    since = 0;
    if (!ill) retired++;
    if (!run_end) begin
      int n = 1 + $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        issue(1'($urandom_range(0, 1)), (j == n - 1), 6'($urandom_range(0, 63)), w_state(0));
      end
    end
  endtask

  // Expands one instruction into its expected cycle sequence; fw/dw are extra memory wait cycles.
  task automatic applyStimulus(int kind, logic [5:0] op, int fw, int dw, logic run_end, bit drop);
    ctl_t w;
    for (int i = 0; i <= fw; i++) issue(i == fw, mid_run(drop), op, w_fetch(i == fw));
    if (kind == K_ILL) begin
      boundary(1'($urandom_range(0, 1)), run_end, op, w_decode(1'b1), 1'b1);
      return;
    end
    issue(1'($urandom_range(0, 1)), mid_run(drop), op, w_decode(1'b0));
    case (kind)
      K_LW: begin
        issue(1'($urandom_range(0, 1)), mid_run(drop), op, w_memaddr());
        for (int i = 0; i <= dw; i++) begin
          w = w_state(4);
          w.mem_read = 1'b1;
          w.i_or_d   = 1'b1;
          issue(i == dw, mid_run(drop), op, w);
        end
        w = w_state(5);
        w.reg_write = 1'b1;  w.mem_to_reg = 1'b1;  w.instr_done = 1'b1;
        boundary(1'($urandom_range(0, 1)), run_end, op, w, 1'b0);
      end
      K_SW: begin
        issue(1'($urandom_range(0, 1)), mid_run(drop), op, w_memaddr());
        for (int i = 0; i < dw; i++) issue(1'b0, mid_run(drop), op, w_memwr(1'b0));
        boundary(1'b1, run_end, op, w_memwr(1'b1), 1'b0);
      end
      K_R: begin
        w = w_state(7);
        w.alu_src_a = 1'b1;  w.alu_op = 2'b10;
        issue(1'($urandom_range(0, 1)), mid_run(drop), op, w);
        w = w_state(8);
        w.reg_write = 1'b1;  w.reg_dst = 1'b1;  w.instr_done = 1'b1;
        boundary(1'($urandom_range(0, 1)), run_end, op, w, 1'b0);
      end
      K_BEQ: begin
        w = w_state(9);
        w.alu_src_a = 1'b1;  w.alu_op = 2'b01;  w.pc_write_cond = 1'b1;
        w.pc_source = 2'b01; w.instr_done = 1'b1;
        boundary(1'($urandom_range(0, 1)), run_end, op, w, 1'b0);
      end
      K_J: begin
        w = w_state(10);
        w.pc_write = 1'b1;  w.pc_source = 2'b10;  w.instr_done = 1'b1;
        boundary(1'($urandom_range(0, 1)), run_end, op, w, 1'b0);
      end
      default: begin
        w = w_state(11);
        w.alu_src_a = 1'b1;  w.alu_src_b = 2'b10;
        issue(1'($urandom_range(0, 1)), mid_run(drop), op, w);
        w = w_state(12);
        w.reg_write = 1'b1;  w.instr_done = 1'b1;
        boundary(1'($urandom_range(0, 1)), run_end, op, w, 1'b0);
      end
    endcase
  endtask

  // Monitor: every scheduled cycle is compared; boundary cycles also pop a retire record.
  always @(negedge clk) begin : monitor
    ctl_t e, a;
    ret_t r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual();
      gap++;
      checkOutput("cycle_word", a, e);
      if (a.instr_done || a.illegal_op) begin
        if (ret_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_boundary at %0t: got boundary in state %0d, expected none",
                   $time, a.st);
        end else begin
          r = ret_q.pop_front();
          checkValue("boundary_kind", int'(a.illegal_op), int'(r.illegal));
          checkValue("boundary_gap", gap, r.gap);
          checkValue("count_at_boundary", int'(instr_count), r.count);
        end
        gap = 0;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    run       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_outputs", actual(), w_state(0));
    checkValue("reset_count", int'(instr_count), 0);
    rst = 1'b0;

    applyStimulus(K_R,   6'h00, 0, 0, 1'b1, 1'b0);
    applyStimulus(K_LW,  6'h23, 0, 2, 1'b1, 1'b0);
    applyStimulus(K_BEQ, 6'h04, 0, 0, 1'b1, 1'b0);
    applyStimulus(K_J,   6'h02, 0, 0, 1'b1, 1'b0);
    applyStimulus(K_ILL, 6'h3F, 0, 0, 1'b1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 6);
      applyStimulus(kind, op_of(kind), $urandom_range(0, 3) / 2, $urandom_range(0, 3) / 2,
                    ($urandom_range(0, 3) != 0), 1'b0);
    end

    applyStimulus(K_SW, 6'h2B, 0, 1, 1'b0, 1'b1);

    // Park an sw in a memory wait, then hit it with an asynchronous reset.
    issue(1'b1, 1'b1, 6'h2B, w_fetch(1'b1));
    issue(1'b1, 1'b1, 6'h2B, w_decode(1'b0));
    issue(1'b1, 1'b0, 6'h2B, w_memaddr());
    issue(1'b0, 1'b1, 6'h2B, w_memwr(1'b0));
    issue(1'b0, 1'b1, 6'h2B, w_memwr(1'b0));
    @(negedge clk);
    #2;
    checkValue("count_before_reset", int'(instr_count), retired % (1 << CW));
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", actual(), w_state(0));
    checkValue("async_reset_count", int'(instr_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkValue("fetch_after_reset", int'(state), 1);

    repeat (2) @(negedge clk);
    checkValue("scoreboard_drained", exp_q.size() + ret_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
